// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch slice.
//   state_t  - fetch controller FSM states (BOOT, RUN, FAULT)
//   ILEN     - instruction / address width
//   PC_STEP  - byte increment between sequential instruction words
//   entry_t  - one FIFO entry: fetch address plus the word read there
//   target_legal() - redirect target check (word aligned, inside memory)
package fetch_pkg;

    localparam int          ILEN    = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    // A redirect may only land on a word boundary inside the memory.
    function automatic logic target_legal(input logic [31:0] target,
                                          input logic [31:0] imem_bytes);
        return (target[1:0] == 2'b00) && (target < imem_bytes);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundle of the fetch controller's memory, redirect and
// decode-side signals.
//   imem_addr / imem_rdata        - combinational-read instruction memory
//   redirect_valid / redirect_pc  - control-flow redirect from execute
//   if_valid / if_ready           - handshake toward decode
//   if_instr / if_pc              - head instruction word and its address
//   fault                         - sticky illegal-redirect indication
// master: the fetch controller side.  slave: memory/decode/execute side.
interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic [ILEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [ILEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [ILEN-1:0] if_instr;
    logic [ILEN-1:0] if_pc;
    logic            fault;

    modport master (
        output imem_addr, if_valid, if_instr, if_pc, fault,
        input  imem_rdata, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_addr, if_valid, if_instr, if_pc, fault,
        output imem_rdata, redirect_valid, redirect_pc, if_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetched {pc, instr} entries.
//   clk, reset      - clock, synchronous active-high reset
//   push / wr_entry - write wr_entry at the tail (accepted when not full, or
//                     when full and a pop happens in the same cycle)
//   pop             - drop the head (ignored when empty)
//   flush           - discard all entries; wins over push and pop
//   full / empty    - occupancy flags, decoded from the count register
//   head            - entry at the read pointer, straight from a slot register
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t wr_entry,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push_eff;
    logic          pop_eff;
    entry_t        slots [DEPTH];

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);

    assign pop_eff  = pop && !flush && !empty;
    // When full, the pop frees the head slot, which is also the tail slot.
    assign push_eff = push && !flush && (!full || pop_eff);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gen_slot
            entry_t slot_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    slot_reg <= '0;
                end else if (push_eff && (wr_ptr_reg == AW'(gi))) begin
                    slot_reg <= wr_entry;
                end
            end

            assign slots[gi] = slot_reg;
        end
    endgenerate

    assign head = slots[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller.
//   clk, reset - clock, synchronous active-high reset
//   bus        - fetch_ctrl_if.master: instruction memory address/data,
//                redirect input, decode handshake (if_valid/if_ready/
//                if_instr/if_pc) and the sticky fault flag.
// Owns fetch_pc, reads one word per cycle from the combinational memory and
// queues {pc, word} in fetch_fifo. A redirect flushes the queue; an illegal
// target parks the controller in FAULT until reset.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int unsigned IMEM_BYTES = 32,
    parameter int unsigned DEPTH      = 2
) (
    input logic          clk,
    input logic          reset,
    fetch_ctrl_if.master bus
);

    localparam logic [31:0] PC_MASK = 32'(IMEM_BYTES - 1);

    state_t      state_reg;
    logic [31:0] fetch_pc_reg;
    logic [31:0] fetch_pc_next;
    logic        fault_reg;

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_flush;
    logic        redirect_run;
    logic        redirect_ok;
    entry_t      fifo_head;
    entry_t      fifo_wr;

    assign redirect_run = (state_reg == RUN) && bus.redirect_valid;
    assign redirect_ok  = target_legal(bus.redirect_pc, 32'(IMEM_BYTES));

    assign fifo_pop   = !fifo_empty && bus.if_ready;
    // if_ready reaches push through here so a full queue still streams.
    assign fifo_push  = (state_reg == RUN) && !bus.redirect_valid &&
                        (!fifo_full || fifo_pop);
    assign fifo_flush = redirect_run;

    assign fetch_pc_next = (fetch_pc_reg + PC_STEP) & PC_MASK;
    assign fifo_wr       = '{pc: fetch_pc_reg, instr: bus.imem_rdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= BOOT;
            fetch_pc_reg <= RESET_PC;
            fault_reg    <= 1'b0;
        end else begin
            case (state_reg)
                BOOT: begin
                    state_reg <= RUN;
                end
                RUN: begin
                    if (bus.redirect_valid) begin
                        if (redirect_ok) begin
                            fetch_pc_reg <= bus.redirect_pc;
                        end else begin
                            // fetch_pc is left untouched so imem_addr holds.
                            state_reg <= FAULT;
                            fault_reg <= 1'b1;
                        end
                    end else if (fifo_push) begin
                        fetch_pc_reg <= fetch_pc_next;
                    end
                end
                FAULT: begin
                    state_reg <= FAULT;
                end
                default: begin
                    state_reg <= FAULT;
                    fault_reg <= 1'b1;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .wr_entry (fifo_wr),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    assign bus.imem_addr = fetch_pc_reg;
    assign bus.if_valid  = !fifo_empty;
    assign bus.if_instr  = fifo_head.instr;
    assign bus.if_pc     = fifo_head.pc;
    assign bus.fault     = fault_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl with
// IMEM_BYTES = 32 (8 words), DEPTH = 2, RESET_PC = 0.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC   = 32'h0;
    localparam int unsigned IMEM_BYTES = 32;
    localparam int unsigned DEPTH      = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_ctrl_if bus();

    logic [31:0] mem [8];
    assign bus.imem_rdata = mem[bus.imem_addr[4:2]];

    fetch_ctrl #(
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (IMEM_BYTES),
        .DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // One line per accepted instruction.
    always @(negedge clk) begin
        if (!reset && bus.if_valid && bus.if_ready)
            $display("[TB] accept pc=%h instr=%h", bus.if_pc, bus.if_instr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_distinct();
        for (int i = 0; i < 8; i++) mem[i] = 32'hA000_0000 + 32'(i);
    endtask

    // Leaves the bench just after E2: head = {pc 0}, count 1, fetch_pc 4.
    task automatic boot();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.if_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        mem[0] = 32'h33E2_6200;
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.if_ready = 1'b1;
        step();
        step();
        tests_run++; if (bus.if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_if_valid: got %b want 0", bus.if_valid); end
        tests_run++; if (bus.if_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_if_pc: got %h want 0", bus.if_pc); end
        tests_run++; if (bus.if_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_if_instr: got %h want 0", bus.if_instr); end
        tests_run++; if (bus.fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
        tests_run++; if (bus.imem_addr !== RESET_PC) begin tests_failed++; $display("FAIL reset_imem_addr: got %h want %h", bus.imem_addr, RESET_PC); end
        tests_run++; if (dut.state_reg !== BOOT) begin tests_failed++; $display("FAIL reset_state: got %0d want BOOT", dut.state_reg); end
        reset = 1'b0;
        step();
        tests_run++; if (bus.if_valid !== 1'b0) begin tests_failed++; $display("FAIL boot_no_fetch: if_valid got %b want 0", bus.if_valid); end
        step();
        tests_run++; if (bus.if_valid !== 1'b1) begin tests_failed++; $display("FAIL boot_first_valid: got %b want 1", bus.if_valid); end
        tests_run++; if (bus.if_pc !== 32'h0) begin tests_failed++; $display("FAIL boot_first_pc: got %h want 0", bus.if_pc); end
        tests_run++; if (bus.if_instr !== 32'h33E2_6200) begin tests_failed++; $display("FAIL boot_first_instr: got %h want 33e26200", bus.if_instr); end
        for (int k = 1; k <= 4; k++) begin
            step();
            tests_run++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(4 * k) || bus.if_instr !== 32'h0) begin
                tests_failed++; $display("FAIL boot_stream: valid=%b pc=%h instr=%h want valid=1 pc=%h instr=0", bus.if_valid, bus.if_pc, bus.if_instr, 32'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        load_distinct();
        boot();
        bus.if_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            tests_run++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin
                tests_failed++; $display("FAIL bp_hold: valid=%b pc=%h want valid=1 pc=0", bus.if_valid, bus.if_pc);
            end
        end
        tests_run++; if (dut.u_fifo.count_reg !== 2'd2) begin tests_failed++; $display("FAIL bp_count: got %0d want 2", dut.u_fifo.count_reg); end
        bus.if_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests_run++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(4 * k) || bus.if_instr !== 32'hA000_0000 + 32'(k)) begin
                tests_failed++; $display("FAIL bp_resume: valid=%b pc=%h instr=%h want pc=%h", bus.if_valid, bus.if_pc, bus.if_instr, 32'(4 * k));
            end
            step();
        end
    endtask

    task automatic test_wrap();
        load_distinct();
        boot();
        for (int k = 0; k < 10; k++) begin
            tests_run++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'((4 * k) % 32) || bus.if_instr !== 32'hA000_0000 + 32'(k % 8)) begin
                tests_failed++; $display("FAIL wrap_seq: valid=%b pc=%h instr=%h want pc=%h", bus.if_valid, bus.if_pc, bus.if_instr, 32'((4 * k) % 32));
            end
            step();
        end
    endtask

    task automatic test_redirect();
        load_distinct();
        boot();
        bus.if_ready = 1'b0;
        step();
        step();
        tests_run++; if (dut.u_fifo.count_reg !== 2'd2) begin tests_failed++; $display("FAIL redir_prefull: count got %0d want 2", dut.u_fifo.count_reg); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'd16;
        step();
        bus.redirect_valid = 1'b0;
        tests_run++; if (bus.if_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_flush_valid: got %b want 0", bus.if_valid); end
        tests_run++; if (bus.imem_addr !== 32'd16) begin tests_failed++; $display("FAIL redir_imem_addr: got %h want 10", bus.imem_addr); end
        tests_run++; if (dut.u_fifo.count_reg !== 2'd0) begin tests_failed++; $display("FAIL redir_count: got %0d want 0", dut.u_fifo.count_reg); end
        bus.if_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests_run++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(16 + 4 * k) || bus.if_instr !== 32'hA000_0004 + 32'(k)) begin
                tests_failed++; $display("FAIL redir_target_seq: valid=%b pc=%h instr=%h want pc=%h", bus.if_valid, bus.if_pc, bus.if_instr, 32'(16 + 4 * k));
            end
        end
    endtask

    task automatic test_illegal_redirect();
        logic [31:0] bad [2];
        bad[0] = 32'd6;
        bad[1] = 32'd32;
        load_distinct();
        for (int t = 0; t < 2; t++) begin
            boot();
            bus.redirect_valid = 1'b1;
            bus.redirect_pc = bad[t];
            step();
            bus.redirect_valid = 1'b0;
            tests_run++; if (bus.fault !== 1'b1 || bus.if_valid !== 1'b0) begin
                tests_failed++; $display("FAIL illegal_enter target=%h: fault=%b valid=%b want fault=1 valid=0", bad[t], bus.fault, bus.if_valid);
            end
            tests_run++; if (bus.imem_addr !== 32'd4) begin tests_failed++; $display("FAIL illegal_addr_hold target=%h: got %h want 4", bad[t], bus.imem_addr); end
            // A later legal redirect must not leave FAULT.
            bus.redirect_valid = 1'b1;
            bus.redirect_pc = 32'd8;
            step();
            bus.redirect_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                step();
                tests_run++; if (bus.fault !== 1'b1 || bus.if_valid !== 1'b0 || bus.imem_addr !== 32'd4) begin
                    tests_failed++; $display("FAIL illegal_sticky target=%h: fault=%b valid=%b addr=%h want 1/0/4", bad[t], bus.fault, bus.if_valid, bus.imem_addr);
                end
            end
            reset = 1'b1;
            step();
            reset = 1'b0;
            tests_run++; if (bus.fault !== 1'b0 || bus.if_valid !== 1'b0 || bus.imem_addr !== RESET_PC) begin
                tests_failed++; $display("FAIL illegal_clear target=%h: fault=%b valid=%b addr=%h want 0/0/0", bad[t], bus.fault, bus.if_valid, bus.imem_addr);
            end
        end
    endtask

    task automatic test_redirect_pop();
        int handshakes;
        load_distinct();
        boot();
        bus.if_ready = 1'b0;
        step();
        handshakes = 0;
        bus.if_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'd24;
        tests_run++; if (bus.if_pc !== 32'h0) begin tests_failed++; $display("FAIL rp_head: got %h want 0", bus.if_pc); end
        if (bus.if_valid && bus.if_ready) handshakes++;
        step();
        bus.redirect_valid = 1'b0;
        tests_run++; if (bus.if_valid !== 1'b0 || dut.u_fifo.count_reg !== 2'd0) begin
            tests_failed++; $display("FAIL rp_flush: valid=%b count=%0d want 0/0", bus.if_valid, dut.u_fifo.count_reg);
        end
        if (bus.if_valid && bus.if_ready) handshakes++;
        step();
        tests_run++; if (handshakes !== 1) begin tests_failed++; $display("FAIL rp_handshakes: got %0d want 1", handshakes); end
        tests_run++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd24 || bus.if_instr !== 32'hA000_0006) begin
            tests_failed++; $display("FAIL rp_target: valid=%b pc=%h instr=%h want 1/18/a0000006", bus.if_valid, bus.if_pc, bus.if_instr);
        end
    endtask

    task automatic test_reset_override();
        load_distinct();
        boot();
        step();
        step();
        reset = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'd6;
        step();
        tests_run++; if (bus.fault !== 1'b0 || bus.if_valid !== 1'b0 || bus.imem_addr !== RESET_PC || dut.state_reg !== BOOT) begin
            tests_failed++; $display("FAIL rst_override: fault=%b valid=%b addr=%h state=%0d want 0/0/0/BOOT", bus.fault, bus.if_valid, bus.imem_addr, dut.state_reg);
        end
        reset = 1'b0;
        bus.redirect_valid = 1'b0;
        step();
        step();
        tests_run++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin
            tests_failed++; $display("FAIL rst_reboot: valid=%b pc=%h want 1/0", bus.if_valid, bus.if_pc);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.if_ready = 1'b0;
        test_reset();
        test_backpressure();
        test_wrap();
        test_redirect();
        test_illegal_redirect();
        test_redirect_pop();
        test_reset_override();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
